// File: rtl/fair_stream_mux.sv
// Purpose : merges NUM_REQS valid/ready streams into one registered output stream with batch-fair arbitration.
// Latency : one cycle from an input handshake to the beat on out_*; one beat per cycle when out_ready stays high.
// Backpressure: out_ready low with a held beat drops every in_ready; the grant and the batch state are frozen until a transfer fires.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   in_valid/in_ready  per-stream handshake; at most one in_ready bit is set
//   in_data            stream i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid/out_ready registered output handshake
//   out_data, out_sel  registered payload and the index of its source stream
module fair_stream_mux #(
    parameter int NUM_REQS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQS-1:0]            in_valid,
    input  logic [NUM_REQS*DATA_WIDTH-1:0] in_data,
    output logic [NUM_REQS-1:0]            in_ready,
    output logic                           out_valid,
    output logic [DATA_WIDTH-1:0]          out_data,
    output logic [SEL_WIDTH-1:0]           out_sel,
    input  logic                           out_ready
);

    logic                  stall;
    logic                  can_load;
    logic                  fire;
    logic [NUM_REQS-1:0]   grant_onehot;
    logic [SEL_WIDTH-1:0]  grant_index;
    logic [DATA_WIDTH-1:0] load_data;

    // The output register may drain and reload in the same cycle.
    assign stall    = out_valid & ~out_ready;
    assign can_load = ~stall;

    // Gating with reset keeps the sources from seeing a handshake that the
    // register stage would discard.
    assign in_ready = grant_onehot & {NUM_REQS{can_load & ~reset}};
    assign fire     = |(in_valid & in_ready);

    generate
        if (NUM_REQS == 1) begin : g_single
            // Single stream: ready follows the register stage alone.
            assign grant_onehot = 1'b1;
            assign grant_index  = '0;
            assign load_data    = in_data[DATA_WIDTH-1:0];
        end else begin : g_multi
            logic [NUM_REQS-1:0] pending;
            logic                batch_active;
            logic [NUM_REQS-1:0] masked;
            logic [NUM_REQS-1:0] req;

            // Requesters still owed a grant in this batch. If all of them have
            // dropped valid, fall back to the live in_valid so nobody starves.
            always_comb begin
                masked = pending & in_valid;
                req    = (batch_active && (masked != '0)) ? masked : in_valid;
            end

            // Fixed priority over req: lowest index wins. Scanning from the top
            // down leaves the lowest set bit as the final assignment.
            always_comb begin
                grant_onehot = '0;
                grant_index  = '0;
                for (int i = NUM_REQS - 1; i >= 0; i--) begin
                    if (req[i]) begin
                        grant_onehot    = '0;
                        grant_onehot[i] = 1'b1;
                        grant_index     = SEL_WIDTH'(i);
                    end
                end
            end

            assign load_data = in_data[grant_index*DATA_WIDTH +: DATA_WIDTH];

            // Batch state moves only on an accepted transfer, so a stalled
            // output keeps the same grant presented to the sources.
            always_ff @(posedge clk) begin
                if (reset) begin
                    pending      <= '0;
                    batch_active <= 1'b0;
                end else if (fire) begin
                    pending      <= req & ~grant_onehot;
                    batch_active <= ((req & ~grant_onehot) != '0);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
        end else if (fire) begin
            out_valid <= 1'b1;
            out_data  <= load_data;
            out_sel   <= grant_index;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fair_stream_mux.sv
module tb_fair_stream_mux;

    localparam int N  = 4;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]  in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_sel;
    logic          out_ready;

    // single-stream build
    logic          v1;
    logic [DW-1:0] d1;
    logic          rdy1;
    logic          ov1;
    logic [DW-1:0] od1;
    logic [0:0]    os1;
    logic          or1;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    fair_stream_mux #(.NUM_REQS(N), .DATA_WIDTH(DW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel),
        .out_ready(out_ready)
    );

    fair_stream_mux #(.NUM_REQS(1), .DATA_WIDTH(DW)) dut1 (
        .clk(clk), .reset(reset),
        .in_valid(v1), .in_data(d1), .in_ready(rdy1),
        .out_valid(ov1), .out_data(od1), .out_sel(os1),
        .out_ready(or1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b1;
        v1        = 1'b0;
        or1       = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        tick();
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        tests_run++;
        if (in_ready !== 4'b0000) begin
            fails++; $display("FAIL reset_in_ready: got %b want 0000", in_ready);
        end
        tests_run++;
        if (out_data !== 32'h0 || out_sel !== 2'd0) begin
            fails++; $display("FAIL reset_out_regs: got data %h sel %0d want 0/0", out_data, out_sel);
        end
        reset = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 4'b0001) begin
            fails++; $display("FAIL reset_first_ready: got %b want 0001", in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 32'hA0) begin
            fails++; $display("FAIL reset_first_beat: got v%b sel %0d data %h want v1 sel 0 data a0",
                              out_valid, out_sel, out_data);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            tests_run++;
            if (out_valid !== 1'b1 || out_sel !== 2'(k % 4) || out_data !== 32'hA0 + 32'(k % 4)) begin
                fails++; $display("FAIL round_robin[%0d]: got v%b sel %0d data %h want v1 sel %0d data %h",
                                  k, out_valid, out_sel, out_data, k % 4, 32'hA0 + 32'(k % 4));
            end
        end
        in_valid = '0;
    endtask

    task automatic test_mid_batch();
        do_reset();
        in_valid = 4'b0110;
        tick();
        tests_run++;
        if (out_sel !== 2'd1 || out_valid !== 1'b1) begin
            fails++; $display("FAIL mid_batch_first: got v%b sel %0d want v1 sel 1", out_valid, out_sel);
        end
        in_valid = 4'b0111;
        #1;
        tests_run++;
        if (in_ready !== 4'b0100) begin
            fails++; $display("FAIL mid_batch_ready: got %b want 0100", in_ready);
        end
        tick();
        tests_run++;
        if (out_sel !== 2'd2 || out_data !== 32'hA2) begin
            fails++; $display("FAIL mid_batch_second: got sel %0d data %h want sel 2 data a2", out_sel, out_data);
        end
        tick();
        tests_run++;
        if (out_sel !== 2'd0 || out_data !== 32'hA0) begin
            fails++; $display("FAIL mid_batch_third: got sel %0d data %h want sel 0 data a0", out_sel, out_data);
        end
        in_valid = '0;
    endtask

    task automatic test_back_pressure();
        logic [15:0] pat;
        int          cnt [N];
        int          delivered;
        pat = 16'b1001_1011_0100_1101;
        do_reset();
        in_valid  = 4'b1111;
        out_ready = 1'b0;
        tick();
        for (int j = 0; j < 3; j++) begin
            tests_run++;
            if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 32'hA0 || in_ready !== 4'b0000) begin
                fails++; $display("FAIL stall_hold[%0d]: got v%b sel %0d data %h rdy %b want v1 sel 0 data a0 rdy 0000",
                                  j, out_valid, out_sel, out_data, in_ready);
            end
            tick();
        end
        out_ready = 1'b1;
        #1;
        tests_run++;
        if (in_ready !== 4'b0010) begin
            fails++; $display("FAIL stall_release_ready: got %b want 0010", in_ready);
        end
        for (int i = 0; i < N; i++) cnt[i] = 0;
        delivered = 0;
        // All streams stay valid, so delivery order is 0,1,2,3,... whatever the stalls.
        for (int c = 0; c < 64 && delivered < 8; c++) begin
            out_ready = (c == 0) ? 1'b1 : pat[c % 16];
            #1;
            if (out_valid && out_ready) begin
                tests_run++;
                if (out_sel !== 2'(delivered % 4) || out_data !== 32'hA0 + 32'(out_sel)) begin
                    fails++; $display("FAIL bp_order[%0d]: got sel %0d data %h want sel %0d",
                                      delivered, out_sel, out_data, delivered % 4);
                end
                cnt[out_sel]++;
                delivered++;
            end
            tick();
        end
        tests_run++;
        if (delivered != 8) begin
            fails++; $display("FAIL bp_timeout: delivered %0d want 8", delivered);
        end
        for (int i = 0; i < N; i++) begin
            tests_run++;
            if (cnt[i] != 2) begin
                fails++; $display("FAIL bp_count[%0d]: got %0d want 2", i, cnt[i]);
            end
        end
        in_valid  = '0;
        out_ready = 1'b1;
    endtask

    task automatic test_dropped_valid();
        do_reset();
        in_valid = 4'b1011;
        tick();
        tests_run++;
        if (out_sel !== 2'd0) begin
            fails++; $display("FAIL drop_first: got sel %0d want 0", out_sel);
        end
        in_valid = 4'b1001;
        #1;
        tests_run++;
        if (in_ready !== 4'b1000) begin
            fails++; $display("FAIL drop_ready: got %b want 1000", in_ready);
        end
        tick();
        tests_run++;
        if (out_sel !== 2'd3 || out_data !== 32'hA3) begin
            fails++; $display("FAIL drop_next: got sel %0d data %h want sel 3 data a3", out_sel, out_data);
        end
        // Fallback: only stream 1 pending, but it has gone away.
        do_reset();
        in_valid = 4'b0011;
        tick();
        in_valid = 4'b0001;
        #1;
        tests_run++;
        if (in_ready !== 4'b0001) begin
            fails++; $display("FAIL fallback_ready: got %b want 0001", in_ready);
        end
        tick();
        tests_run++;
        if (out_valid !== 1'b1 || out_sel !== 2'd0 || out_data !== 32'hA0) begin
            fails++; $display("FAIL fallback_grant: got v%b sel %0d data %h want v1 sel 0 data a0",
                              out_valid, out_sel, out_data);
        end
        in_valid = '0;
    endtask

    task automatic test_single();
        int unsigned tx_seq;
        int unsigned rx_seq;
        logic        fire_now;
        logic [DW-1:0] last;
        do_reset();
        tx_seq = 32'h100;
        rx_seq = 32'h100;
        for (int c = 0; c < 200; c++) begin
            v1  = 1'($urandom_range(0, 1));
            or1 = 1'($urandom_range(0, 1));
            d1  = tx_seq;
            #1;
            if (ov1 && !or1) begin
                tests_run++;
                if (rdy1 !== 1'b0) begin
                    fails++; $display("FAIL single_stall_ready[%0d]: got %b want 0", c, rdy1);
                end
            end
            if (ov1 && or1) begin
                tests_run++;
                if (od1 !== rx_seq || os1 !== 1'b0) begin
                    fails++; $display("FAIL single_rx[%0d]: got data %h sel %0d want data %h sel 0",
                                      c, od1, os1, rx_seq);
                end
                rx_seq++;
            end
            fire_now = v1 & rdy1;
            last     = d1;
            if (fire_now) tx_seq++;
            tick();
            if (fire_now) begin
                tests_run++;
                if (ov1 !== 1'b1 || od1 !== last || os1 !== 1'b0) begin
                    fails++; $display("FAIL single_latency[%0d]: got v%b data %h sel %0d want v1 data %h sel 0",
                                      c, ov1, od1, os1, last);
                end
            end
        end
        tests_run++;
        if (tx_seq != rx_seq + 32'(ov1)) begin
            fails++; $display("FAIL single_conservation: sent %0d delivered %0d held %0d",
                              tx_seq - 32'h100, rx_seq - 32'h100, ov1);
        end
        v1 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = 32'hA0 + 32'(i);
        d1        = '0;
        v1        = 1'b0;
        or1       = 1'b1;
        reset     = 1'b1;
        in_valid  = '0;
        out_ready = 1'b1;
        #2;
        test_reset();
        test_round_robin();
        test_mid_batch();
        test_back_pressure();
        test_dropped_valid();
        test_single();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/fair_stream_mux.md
Name: fair_stream_mux

Overview:
- Merges NUM_REQS valid/ready request streams into one registered output stream, using batch-fair arbitration.
- Sits directly downstream of the request sources and upstream of a shared consumer (e.g. memory port or dispatch slot); it owns the grant→data-mux→output-register path.
- Guarantees every requester valid at batch start is served exactly once before any requester is served twice.

Parameters:
NUM_REQS, 4, number of input streams (>=1)
DATA_WIDTH, 32, payload width per stream
SEL_WIDTH, max(1, clog2(NUM_REQS)), width of source index

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
in_valid  in  NUM_REQS  per-stream valid
in_data  in  NUM_REQS*DATA_WIDTH  per-stream payload, stream i at bits [i*DATA_WIDTH +: DATA_WIDTH]
in_ready  out  NUM_REQS  per-stream ready; at most one bit set
out_valid  out  1  output register holds a beat
out_data  out  DATA_WIDTH  registered payload
out_sel  out  SEL_WIDTH  index of the source stream of the registered beat
out_ready  in  1  consumer accepts the beat

Behaviour:
- Reset values: out_valid=0, out_data=0, out_sel=0, pending=0, batch_active=0. in_ready is combinational and is 0 during reset.
- stall = out_valid & ~out_ready. can_load = ~stall.
- Request mask:
  - req = batch_active ? (pending & in_valid) : in_valid.
  - If batch_active and (pending & in_valid)==0, req = in_valid. This is a fallback; a pending requester that drops valid never deadlocks the mux.
- Grant: grant_onehot = lowest set bit of req (fixed priority, index 0 highest). grant_index is the encoded value of grant_onehot.
- in_ready = grant_onehot & {NUM_REQS{can_load}}, so in_ready is 0 whenever stall=1. Handshake: a transfer fires when in_valid[i] & in_ready[i].
- On a fire (clk edge):
  - out_data <= in_data[grant_index]; out_sel <= grant_index; out_valid <= 1.
  - next = req & ~grant_onehot; pending <= next; batch_active <= (next != 0).
- If no fire and out_ready=1, out_valid <= 0.
- If no fire, pending and batch_active hold. Arbitration state advances only on an accepted transfer (locked grant), so the grant is stable across output back-pressure.
- Latency: input beat appears on out_* 1 cycle after acceptance. Throughput: 1 beat/cycle when out_ready stays high (simultaneous drain and load allowed).
- Batch semantics: with streams 0..N-1 continuously valid, grants cycle 0,1,...,N-1,0,... A stream that raises valid mid-batch waits for the next batch, even if it is lower-indexed.
- NUM_REQS==1: no arbitration state; in_ready = can_load; out_sel=0; otherwise identical register stage.
- No valid inputs: in_ready=0, state holds, and the output drains as normal.
- Reset mid-operation: an in-flight out beat is dropped, pending is cleared, and the next batch starts fresh from the live in_valid.
- Inputs must hold in_valid/in_data stable until accepted (standard protocol). Violations only affect fairness, never correctness of transferred data.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=4'b1111 → out_valid=0, in_ready=0. First cycle after release: in_ready=4'b0001, and out_sel=0 one cycle later.
- Full round-robin: in_valid=4'b1111 held, out_ready=1, in_data[i]=0xA0+i → out_sel sequence 0,1,2,3,0,1 on consecutive cycles, with out_data matching 0xA0..0xA3.
- Mid-batch arrival: in_valid=4'b0110 → stream 1 is granted. Then raise bit0 → the next grant is stream 2, not 0, and stream 0 is granted after it.
- Back-pressure: out_ready=0 for 3 cycles with a beat held → out_data/out_sel are stable and in_ready=0. Releasing out_ready gives the next beat the following cycle with no lost or duplicated beat; a scoreboard confirms the counts per source.
- Dropped pending valid: in_valid=4'b1011, grant 0, then deassert bit1 → the next grant is 3 (fallback not needed). With in_valid=4'b0001 only and pending={1}, it falls back and grants 0 with no stall.
- NUM_REQS=1 build: random valid/ready → output equals input stream delayed 1 cycle, out_sel=0 always, and no beats are lost.
